// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 0 is instruction fetch, port 1 is load/store. One access per cycle;
// reads return one cycle after the grant, writes are acknowledged by gnt.
module mem_port_arbiter #(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int CNT_WIDTH_P       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_p0_req,
  input  logic                         i_p0_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_p0_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_p0_wr_data,
  output logic                         o_p0_gnt,
  output logic                         o_p0_rsp_valid,
  output logic [DATA_WIDTH_P-1:0]      o_p0_rd_data,
  input  logic                         i_p1_req,
  input  logic                         i_p1_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_p1_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_p1_wr_data,
  output logic                         o_p1_gnt,
  output logic                         o_p1_rsp_valid,
  output logic [DATA_WIDTH_P-1:0]      o_p1_rd_data,
  output logic                         o_mem_wr_en,
  output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data,
  output logic [CNT_WIDTH_P-1:0]       o_conflict_cnt
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                        last_gnt;
  port_e                        rsp_port;
  logic                         rsp_pending;
  logic [DATA_ADDR_WIDTH_P-1:0] addr_hold;
  logic [CNT_WIDTH_P-1:0]       conflict_cnt;
  logic                         gnt0;
  logic                         gnt1;

  // Round-robin grant; forced off while reset is held so nothing reaches memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (i_p0_req && i_p1_req) begin
        gnt0 = (last_gnt == PORT1);
        gnt1 = (last_gnt == PORT0);
      end else begin
        gnt0 = i_p0_req;
        gnt1 = i_p1_req;
      end
    end
  end

  // Memory drive: granted port's request, otherwise a harmless read of the held address.
  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = addr_hold;
    o_mem_wr_data = '0;
    if (gnt0) begin
      o_mem_wr_en   = i_p0_wr_en;
      o_mem_addr    = i_p0_addr;
      o_mem_wr_data = i_p0_wr_data;
    end else if (gnt1) begin
      o_mem_wr_en   = i_p1_wr_en;
      o_mem_addr    = i_p1_addr;
      o_mem_wr_data = i_p1_wr_data;
    end
  end

  // Port-facing outputs; read data is a straight pass-through qualified by rsp_valid.
  always_comb begin
    o_p0_gnt       = gnt0;
    o_p1_gnt       = gnt1;
    o_p0_rsp_valid = rsp_pending && (rsp_port == PORT0);
    o_p1_rsp_valid = rsp_pending && (rsp_port == PORT1);
    o_p0_rd_data   = i_mem_rd_data;
    o_p1_rd_data   = i_mem_rd_data;
    o_conflict_cnt = conflict_cnt;
  end

  // Arbitration pointer, response tracking, held address and saturating conflict count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt     <= PORT1;
      rsp_pending  <= 1'b0;
      rsp_port     <= PORT0;
      addr_hold    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        last_gnt  <= gnt1 ? PORT1 : PORT0;
        addr_hold <= o_mem_addr;
      end
      rsp_pending <= (gnt0 && !i_p0_wr_en) || (gnt1 && !i_p1_wr_en);
      if ((gnt0 && !i_p0_wr_en) || (gnt1 && !i_p1_wr_en)) begin
        rsp_port <= gnt1 ? PORT1 : PORT0;
      end
      if (i_p0_req && i_p1_req && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule
